// File: rtl/rv32i_pipe_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline sequencing controller: FSM states,
// per-stage stall/flush bit positions and default timing parameters.
package rv32i_pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_LU       = 2'd2,
      ST_REDIRECT = 2'd3
   } ctrl_state_e;

   localparam int STG_PC    = 0;
   localparam int STG_IFID  = 1;
   localparam int STG_IDEX  = 2;
   localparam int STG_EXMEM = 3;
   localparam int STG_MEMWB = 4;

   localparam logic [4:0] BIT_PC    = 5'b00001 << STG_PC;
   localparam logic [4:0] BIT_IFID  = 5'b00001 << STG_IFID;
   localparam logic [4:0] BIT_IDEX  = 5'b00001 << STG_IDEX;
   localparam logic [4:0] BIT_EXMEM = 5'b00001 << STG_EXMEM;
   localparam logic [4:0] BIT_MEMWB = 5'b00001 << STG_MEMWB;

   // Memory wait freezes everything up to EX/MEM and bubbles WB.
   localparam logic [4:0] STALL_MEM = BIT_PC | BIT_IFID | BIT_IDEX | BIT_EXMEM;
   localparam logic [4:0] FLUSH_MEM = BIT_MEMWB;
   localparam logic [4:0] STALL_LU  = BIT_PC | BIT_IFID;
   localparam logic [4:0] FLUSH_LU  = BIT_IDEX;
   localparam logic [4:0] FLUSH_RED = BIT_IFID | BIT_IDEX;
   localparam logic [4:0] FLUSH_BUB = BIT_IFID;

   localparam int RedirectBubbles = 1;
   localparam int LuStall         = 1;
   localparam int MemTimeout      = 255;

endpackage

// File: rtl/rv32i_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX.
module rv32i_hazard_detect
   import rv32i_pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1_addr,
   input  logic [4:0] id_rs2_addr,
   input  logic       id_rs1_re,
   input  logic       id_rs2_re,
   input  logic       ex_we,
   input  logic [4:0] ex_waddr,
   input  logic       ex_is_load,
   output logic       luhaz
);

   logic rs1_hit;
   logic rs2_hit;

   always_comb begin
      rs1_hit = id_rs1_re & (id_rs1_addr == ex_waddr);
      rs2_hit = id_rs2_re & (id_rs2_addr == ex_waddr);
      // x0 is never a real dependency.
      luhaz   = ex_is_load & ex_we & (ex_waddr != 5'd0) & (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline sequencing controller: prioritises memory waits, EX redirects and
// load-use hazards into per-stage stall/flush enables and a PC redirect.
module rv32i_pipe_ctrl
   import rv32i_pipe_ctrl_pkg::*;
#(
   parameter int REDIRECT_BUBBLES = RedirectBubbles,
   parameter int LU_STALL         = LuStall,
   parameter int MEM_TIMEOUT      = MemTimeout
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        id_rs1_re_i,
   input  logic        id_rs2_re_i,
   input  logic        ex_we_i,
   input  logic [4:0]  ex_waddr_i,
   input  logic        ex_is_load_i,
   input  logic        ex_jump_flag_i,
   input  logic [31:0] ex_jump_pc_i,
   input  logic        ex_ctrl_flag_i,
   input  logic [31:0] ex_branch_pc_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   output logic [4:0]  stall_o,
   output logic [4:0]  flush_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic        mem_err_o,
   output logic [1:0]  state_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   ctrl_state_e state;
   ctrl_state_e state_nxt;
   logic [2:0]  cnt;
   logic [2:0]  cnt_nxt;
   logic [15:0] tcnt;
   logic [15:0] tcnt_nxt;
   logic        pend_vld;
   logic        pend_vld_nxt;
   logic [31:0] pend_pc;
   logic [31:0] pend_pc_nxt;
   logic        mem_err;
   logic        err_set;

   logic        memwait;
   logic        redir;
   logic        luhaz;
   logic [31:0] target;

   logic [4:0]  stall;
   logic [4:0]  flush;
   logic        redirect;
   logic [31:0] redirect_pc;

   rv32i_hazard_detect u_hazard (
      .id_rs1_addr (id_rs1_addr_i),
      .id_rs2_addr (id_rs2_addr_i),
      .id_rs1_re   (id_rs1_re_i),
      .id_rs2_re   (id_rs2_re_i),
      .ex_we       (ex_we_i),
      .ex_waddr    (ex_waddr_i),
      .ex_is_load  (ex_is_load_i),
      .luhaz       (luhaz)
   );

   always_comb begin
      memwait = mem_req_i & ~mem_ack_i;
      redir   = ex_jump_flag_i | ex_ctrl_flag_i;
      target  = ex_jump_flag_i ? ex_jump_pc_i : ex_branch_pc_i;
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      tcnt_nxt     = tcnt;
      pend_vld_nxt = pend_vld;
      pend_pc_nxt  = pend_pc;
      err_set      = 1'b0;
      stall        = '0;
      flush        = '0;
      redirect     = 1'b0;
      redirect_pc  = '0;

      unique case (state)
         ST_RUN: begin
            if (memwait) begin
               stall     = STALL_MEM;
               flush     = FLUSH_MEM;
               // The redirecting instruction stays frozen in EX; remember its target.
               if (redir && !pend_vld) begin
                  pend_vld_nxt = 1'b1;
                  pend_pc_nxt  = target;
               end
               state_nxt = ST_MEM_WAIT;
               tcnt_nxt  = '0;
            end else if (pend_vld || redir) begin
               redirect     = 1'b1;
               redirect_pc  = pend_vld ? pend_pc : target;
               flush        = FLUSH_RED;
               pend_vld_nxt = 1'b0;
               if (REDIRECT_BUBBLES > 0) begin
                  state_nxt = ST_REDIRECT;
                  cnt_nxt   = 3'(REDIRECT_BUBBLES);
               end
            end else if (luhaz) begin
               stall = STALL_LU;
               flush = FLUSH_LU;
               if (LU_STALL > 1) begin
                  state_nxt = ST_LU;
                  cnt_nxt   = 3'(LU_STALL - 1);
               end
            end
         end

         ST_LU: begin
            if (memwait) begin
               stall     = STALL_MEM;
               flush     = FLUSH_MEM;
               state_nxt = ST_MEM_WAIT;
               tcnt_nxt  = '0;
            end else begin
               stall   = STALL_LU;
               flush   = FLUSH_LU;
               cnt_nxt = cnt - 3'd1;
               if (cnt <= 3'd1) begin
                  state_nxt = ST_RUN;
               end
            end
         end

         ST_MEM_WAIT: begin
            stall    = STALL_MEM;
            flush    = FLUSH_MEM;
            tcnt_nxt = tcnt + 16'd1;
            if (mem_ack_i) begin
               state_nxt = ST_RUN;
            end else if (tcnt == 16'(MEM_TIMEOUT - 1)) begin
               err_set   = 1'b1;
               state_nxt = ST_RUN;
            end
         end

         ST_REDIRECT: begin
            // EX holds a bubble here, so any redir seen now is stale.
            flush   = FLUSH_BUB;
            cnt_nxt = cnt - 3'd1;
            if (cnt <= 3'd1) begin
               state_nxt = ST_RUN;
            end
         end

         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   always_comb begin
      if (rst) begin
         stall_o       = '0;
         flush_o       = '0;
         redirect_o    = 1'b0;
         redirect_pc_o = '0;
      end else begin
         stall_o       = stall;
         flush_o       = flush;
         redirect_o    = redirect;
         redirect_pc_o = redirect_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         cnt         <= '0;
         tcnt        <= '0;
         pend_vld    <= 1'b0;
         mem_err     <= 1'b0;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         tcnt     <= tcnt_nxt;
         pend_vld <= pend_vld_nxt;
         if (err_set) begin
            mem_err <= 1'b1;
         end
         if (|stall) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
         end
         if (redirect) begin
            flush_cnt_o <= flush_cnt_o + 32'd1;
         end
      end
   end

   // Target is only meaningful while pend_vld is set.
   always_ff @(posedge clk) begin
      pend_pc <= pend_pc_nxt;
   end

   assign mem_err_o = mem_err;
   assign state_o   = state;

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Scoreboard bench for rv32i_pipe_ctrl: each cycle's stimulus carries its
// expected outputs, which are queued when driven and compared mid-cycle.
module tb_rv32i_pipe_ctrl;

   localparam logic [4:0] S_MEM = 5'b01111;
   localparam logic [4:0] F_MEM = 5'b10000;
   localparam logic [4:0] S_LU  = 5'b00011;
   localparam logic [4:0] F_LU  = 5'b00100;
   localparam logic [4:0] F_RD  = 5'b00110;
   localparam logic [4:0] F_BUB = 5'b00010;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rs1_re;
      logic        rs2_re;
      logic        we;
      logic [4:0]  waddr;
      logic        ld;
      logic        jf;
      logic [31:0] jpc;
      logic        cf;
      logic [31:0] bpc;
      logic        mreq;
      logic        mack;
   } in_t;

   typedef struct packed {
      logic [4:0]  stall;
      logic [4:0]  flush;
      logic        redir;
      logic [31:0] pc;
      logic [1:0]  state;
      logic        err;
   } obs_t;

   typedef struct packed {
      logic rst;
      in_t  in;
      obs_t exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   in_t         drv = '0;
   logic [4:0]  stall_o;
   logic [4:0]  flush_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        mem_err_o;
   logic [1:0]  state_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;

   int          checks = 0;
   int          errors = 0;
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;
   obs_t        exp_q[$];

   always #5 clk = ~clk;

   rv32i_pipe_ctrl #(
      .REDIRECT_BUBBLES (1),
      .LU_STALL         (1),
      .MEM_TIMEOUT      (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .id_rs1_addr_i  (drv.rs1),
      .id_rs2_addr_i  (drv.rs2),
      .id_rs1_re_i    (drv.rs1_re),
      .id_rs2_re_i    (drv.rs2_re),
      .ex_we_i        (drv.we),
      .ex_waddr_i     (drv.waddr),
      .ex_is_load_i   (drv.ld),
      .ex_jump_flag_i (drv.jf),
      .ex_jump_pc_i   (drv.jpc),
      .ex_ctrl_flag_i (drv.cf),
      .ex_branch_pc_i (drv.bpc),
      .mem_req_i      (drv.mreq),
      .mem_ack_i      (drv.mack),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .redirect_o     (redirect_o),
      .redirect_pc_o  (redirect_pc_o),
      .mem_err_o      (mem_err_o),
      .state_o        (state_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   function automatic obs_t mk(logic [4:0] s, logic [4:0] f, logic r,
                               logic [31:0] pc, logic [1:0] st, logic e);
      return {s, f, r, pc, st, e};
   endfunction

   function automatic in_t lu_in(logic [4:0] waddr, logic [4:0] rs1, logic re1,
                                 logic [4:0] rs2, logic re2);
      in_t s;
      s = '0;
      s.ld = 1'b1; s.we = 1'b1; s.waddr = waddr;
      s.rs1 = rs1; s.rs1_re = re1; s.rs2 = rs2; s.rs2_re = re2;
      return s;
   endfunction

   function automatic in_t br_in(logic jf, logic [31:0] jpc, logic cf, logic [31:0] bpc);
      in_t s;
      s = '0;
      s.jf = jf; s.jpc = jpc; s.cf = cf; s.bpc = bpc;
      return s;
   endfunction

   function automatic in_t mem_in(logic req, logic ack);
      in_t s;
      s = '0;
      s.mreq = req; s.mack = ack;
      return s;
   endfunction

   task automatic test_reset();
      vec_t v[$];
      obs_t got, want;
      in_t  s;
      s = mem_in(1'b1, 1'b0); s.jf = 1'b1; s.jpc = 32'h123;
      v.push_back('{1'b1, s,  mk(5'b0, 5'b0, 1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, '0, mk(5'b0, 5'b0, 1'b0, 32'h0, 2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL reset[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      vec_t v[$];
      obs_t got, want;
      v.push_back('{1'b0, lu_in(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), mk(S_LU, F_LU, 1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                                  mk(5'b0, 5'b0, 1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, lu_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), mk(5'b0, 5'b0, 1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, lu_in(5'd7, 5'd3, 1'b1, 5'd7, 1'b0), mk(5'b0, 5'b0, 1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, lu_in(5'd7, 5'd3, 1'b1, 5'd7, 1'b1), mk(S_LU, F_LU, 1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, lu_in(5'd9, 5'd9, 1'b0, 5'd1, 1'b1), mk(5'b0, 5'b0, 1'b0, 32'h0, 2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL load_use[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL load_use[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      vec_t v[$];
      obs_t got, want;
      v.push_back('{1'b0, br_in(1'b0, 32'h0, 1'b1, 32'h100), mk(5'b0, F_RD,  1'b1, 32'h100, 2'd0, 1'b0)});
      v.push_back('{1'b0, br_in(1'b0, 32'h0, 1'b1, 32'h999), mk(5'b0, F_BUB, 1'b0, 32'h0,   2'd3, 1'b0)});
      v.push_back('{1'b0, '0,                                mk(5'b0, 5'b0,  1'b0, 32'h0,   2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL branch[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL branch[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jump_priority();
      vec_t v[$];
      obs_t got, want;
      in_t  s;
      v.push_back('{1'b0, br_in(1'b1, 32'h200, 1'b1, 32'h300), mk(5'b0, F_RD,  1'b1, 32'h200, 2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                                  mk(5'b0, F_BUB, 1'b0, 32'h0,   2'd3, 1'b0)});
      s = lu_in(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); s.cf = 1'b1; s.bpc = 32'h44;
      v.push_back('{1'b0, s,                                   mk(5'b0, F_RD,  1'b1, 32'h44,  2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                                  mk(5'b0, F_BUB, 1'b0, 32'h0,   2'd3, 1'b0)});
      v.push_back('{1'b0, '0,                                  mk(5'b0, 5'b0,  1'b0, 32'h0,   2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL jump_priority[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL jump_priority[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      vec_t v[$];
      obs_t got, want;
      in_t  s;
      s = lu_in(5'd6, 5'd6, 1'b1, 5'd0, 1'b0); s.mreq = 1'b1;
      v.push_back('{1'b0, s,                   mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, mem_in(1'b1, 1'b0),  mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd1, 1'b0)});
      v.push_back('{1'b0, mem_in(1'b1, 1'b0),  mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd1, 1'b0)});
      v.push_back('{1'b0, mem_in(1'b1, 1'b1),  mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd1, 1'b0)});
      v.push_back('{1'b0, '0,                  mk(5'b0,  5'b0,  1'b0, 32'h0, 2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL mem_wait[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL mem_wait[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_redirect();
      vec_t v[$];
      obs_t got, want;
      in_t  s;
      s = mem_in(1'b1, 1'b0); s.jf = 1'b1; s.jpc = 32'h40;
      v.push_back('{1'b0, s,                   mk(S_MEM, F_MEM, 1'b0, 32'h0,  2'd0, 1'b0)});
      v.push_back('{1'b0, s,                   mk(S_MEM, F_MEM, 1'b0, 32'h0,  2'd1, 1'b0)});
      v.push_back('{1'b0, mem_in(1'b1, 1'b1),  mk(S_MEM, F_MEM, 1'b0, 32'h0,  2'd1, 1'b0)});
      v.push_back('{1'b0, '0,                  mk(5'b0,  F_RD,  1'b1, 32'h40, 2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                  mk(5'b0,  F_BUB, 1'b0, 32'h0,  2'd3, 1'b0)});
      v.push_back('{1'b0, '0,                  mk(5'b0,  5'b0,  1'b0, 32'h0,  2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL mem_redirect[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL mem_redirect[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      vec_t v[$];
      obs_t got, want;
      v.push_back('{1'b0, br_in(1'b0, 32'h0, 1'b1, 32'h500), mk(5'b0, F_RD,  1'b1, 32'h500, 2'd0, 1'b0)});
      v.push_back('{1'b0, br_in(1'b0, 32'h0, 1'b1, 32'h600), mk(5'b0, F_BUB, 1'b0, 32'h0,   2'd3, 1'b0)});
      v.push_back('{1'b0, br_in(1'b1, 32'h700, 1'b0, 32'h0), mk(5'b0, F_RD,  1'b1, 32'h700, 2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                                mk(5'b0, F_BUB, 1'b0, 32'h0,   2'd3, 1'b0)});
      v.push_back('{1'b0, lu_in(5'd8, 5'd1, 1'b1, 5'd8, 1'b1), mk(S_LU, F_LU, 1'b0, 32'h0,  2'd0, 1'b0)});
      v.push_back('{1'b0, lu_in(5'd2, 5'd2, 1'b1, 5'd0, 1'b0), mk(S_LU, F_LU, 1'b0, 32'h0,  2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                                mk(5'b0, 5'b0,  1'b0, 32'h0,   2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL back_to_back[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL back_to_back[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      vec_t v[$];
      obs_t got, want;
      v.push_back('{1'b0, mem_in(1'b1, 1'b0), mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd0, 1'b0)});
      for (int k = 0; k < 4; k++)
         v.push_back('{1'b0, mem_in(1'b1, 1'b0), mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd1, 1'b0)});
      v.push_back('{1'b0, '0,                 mk(5'b0,  5'b0,  1'b0, 32'h0, 2'd0, 1'b1)});
      v.push_back('{1'b0, '0,                 mk(5'b0,  5'b0,  1'b0, 32'h0, 2'd0, 1'b1)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL timeout[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL timeout[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_wait();
      vec_t v[$];
      obs_t got, want;
      in_t  s;
      s = mem_in(1'b1, 1'b0); s.cf = 1'b1; s.bpc = 32'h80;
      v.push_back('{1'b0, s,                  mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd0, 1'b1)});
      v.push_back('{1'b0, s,                  mk(S_MEM, F_MEM, 1'b0, 32'h0, 2'd1, 1'b1)});
      v.push_back('{1'b1, s,                  mk(5'b0,  5'b0,  1'b0, 32'h0, 2'd1, 1'b1)});
      v.push_back('{1'b1, s,                  mk(5'b0,  5'b0,  1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                 mk(5'b0,  5'b0,  1'b0, 32'h0, 2'd0, 1'b0)});
      v.push_back('{1'b0, '0,                 mk(5'b0,  5'b0,  1'b0, 32'h0, 2'd0, 1'b0)});
      foreach (v[i]) begin
         rst = v[i].rst; drv = v[i].in;
         exp_q.push_back(v[i].exp);
         @(negedge clk);
         want = exp_q.pop_front();
         got  = {stall_o, flush_o, redirect_o, redirect_pc_o, state_o, mem_err_o};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset_mid_wait[%0d] outputs: got %h required %h", i, got, want);
         end
         checks++;
         if (stall_cnt_o !== m_stall || flush_cnt_o !== m_flush) begin
            errors++;
            $display("FAIL reset_mid_wait[%0d] counters: got %0d/%0d required %0d/%0d",
                     i, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
         end
         if (v[i].rst) begin m_stall = 0; m_flush = 0; end
         else begin m_stall += (want.stall != 0); m_flush += want.redir; end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      drv = '0;
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_branch();
      test_jump_priority();
      test_mem_wait();
      test_mem_redirect();
      test_back_to_back();
      test_timeout();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
